// File: rtl/reg_hazard_tracker.sv
`default_nettype none
// ============================================================================
// Module   : reg_hazard_tracker
// Purpose  : Decode-stage hazard unit. Keeps the destination registers of
//            in-flight instructions in a DEPTH-entry shift pipeline
//            (entry 0 = EX, 1 = MEM, 2 = WB). Each cycle it compares NUM_SRC
//            source register numbers against every tracked entry. It drives a
//            per-source forwarding select and a load-use stall.
// Ports    : clk          rising-edge clock
//            reset_n      asynchronous active-low reset
//            flush        synchronous pipeline flush (clears all valid bits)
//            issue_valid  decode holds a real instruction
//            issue_wr     instruction writes a register
//            issue_load   instruction is a load
//            issue_dst    destination register number
//            src_valid    per-source "operand is read"
//            src_addr     source numbers, src i at [i*ADDR_W +: ADDR_W]
//            fwd_sel      per-source select: 0 = regfile, k+1 = entry k
//            stall        hold decode/fetch and bubble EX (combinational)
//            stall_cnt    (HAZ_STATS_EN) saturating count of stall cycles
//            fwd_cnt      (HAZ_STATS_EN) saturating count of forward cycles
// Options  : HAZ_STATS_EN adds the stall_cnt/fwd_cnt statistics counters.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module reg_hazard_tracker #(
  parameter  int ADDR_W   = 5,
  parameter  int NUM_SRC  = 2,
  parameter  int DEPTH    = 3,
  parameter  int ZERO_REG = 31,
  localparam int SEL_W    = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      flush,
  input  logic                      issue_valid,
  input  logic                      issue_wr,
  input  logic                      issue_load,
  input  logic [ADDR_W-1:0]         issue_dst,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  output logic                      stall
`ifdef HAZ_STATS_EN
  ,
  output logic [31:0]               stall_cnt,
  output logic [31:0]               fwd_cnt
`else
  // statistics ports are absent in this build
`endif
);

  localparam logic [ADDR_W-1:0] c_zero_reg = ADDR_W'(ZERO_REG);

  // Tracked entry state {v, wr, ld, dst}
  logic [DEPTH-1:0]  r_v;
  logic [DEPTH-1:0]  r_wr;
  logic [DEPTH-1:0]  r_ld;
  logic [ADDR_W-1:0] r_dst [DEPTH];

  logic [NUM_SRC*SEL_W-1:0] w_fwd_sel;
  logic                     w_stall;

  // Match search. Entries are scanned oldest-first so that a later hit on a
  // younger entry overwrites the select; the youngest producer wins.
  always_comb begin
    logic [ADDR_W-1:0] w_addr;
    logic [SEL_W-1:0]  w_sel;
    w_fwd_sel = '0;
    w_stall   = 1'b0;
    w_addr    = '0;
    w_sel     = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_addr = src_addr[i*ADDR_W +: ADDR_W];
      w_sel  = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (src_valid[i] && r_v[k] && r_wr[k] &&
            (r_dst[k] == w_addr) && (w_addr != c_zero_reg)) begin
          w_sel = SEL_W'(k + 1);
        end
      end
      w_fwd_sel[i*SEL_W +: SEL_W] = w_sel;
      // A load still in EX cannot forward yet: load-use stall.
      if ((w_sel == SEL_W'(1)) && r_ld[0]) begin
        w_stall = 1'b1;
      end
    end
  end

  assign fwd_sel = w_fwd_sel;
  assign stall   = w_stall;

  // Entry pipeline: flush beats stall, stall injects a bubble into EX while
  // older entries keep draining, otherwise the decode instruction enters EX.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_v  <= '0;
      r_wr <= '0;
      r_ld <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_dst[k] <= '0;
      end
    end else if (flush) begin
      r_v <= '0;
    end else begin
      for (int k = 1; k < DEPTH; k++) begin
        r_v[k]   <= r_v[k-1];
        r_wr[k]  <= r_wr[k-1];
        r_ld[k]  <= r_ld[k-1];
        r_dst[k] <= r_dst[k-1];
      end
      if (w_stall) begin
        r_v[0] <= 1'b0;
      end else begin
        r_v[0]   <= issue_valid;
        r_wr[0]  <= issue_wr;
        r_ld[0]  <= issue_load;
        r_dst[0] <= issue_dst;
      end
    end
  end

`ifdef HAZ_STATS_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_fwd_cnt;
  logic        w_any_fwd;

  assign w_any_fwd = |w_fwd_sel;

  // Saturating counters; flush intentionally leaves them untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
      r_fwd_cnt   <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (w_any_fwd && !w_stall && (r_fwd_cnt != 32'hFFFF_FFFF)) begin
        r_fwd_cnt <= r_fwd_cnt + 32'd1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign fwd_cnt   = r_fwd_cnt;
`else
  // No statistics logic in this build; hazard behaviour is unchanged.
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_hazard_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_hazard_tracker
// Purpose  : Directed scoreboard bench for reg_hazard_tracker (default
//            parameters). Stimulus pushes hand-computed expectations; a monitor
//            pops and compares at each negative clock edge or reset assertion.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_hazard_tracker;

  localparam int ADDR_W  = 5;
  localparam int NUM_SRC = 2;
  localparam int SEL_W   = 2;

  logic                      clk = 1'b0;
  logic                      reset_n = 1'b0;
  logic                      flush = 1'b0;
  logic                      issue_valid = 1'b0;
  logic                      issue_wr = 1'b0;
  logic                      issue_load = 1'b0;
  logic [ADDR_W-1:0]         issue_dst = '0;
  logic [NUM_SRC-1:0]        src_valid = '0;
  logic [NUM_SRC*ADDR_W-1:0] src_addr = '0;
  logic [NUM_SRC*SEL_W-1:0]  fwd_sel;
  logic                      stall;
`ifdef HAZ_STATS_EN
  logic [31:0]               stall_cnt;
  logic [31:0]               fwd_cnt;
`endif

  reg_hazard_tracker dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush),
    .issue_valid (issue_valid),
    .issue_wr    (issue_wr),
    .issue_load  (issue_load),
    .issue_dst   (issue_dst),
    .src_valid   (src_valid),
    .src_addr    (src_addr),
    .fwd_sel     (fwd_sel),
    .stall       (stall)
`ifdef HAZ_STATS_EN
    ,
    .stall_cnt   (stall_cnt),
    .fwd_cnt     (fwd_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [SEL_W-1:0] sel0;
    logic [SEL_W-1:0] sel1;
    logic             stl;
  } exp_t;

  exp_t  exp_q  [$];
  string name_q [$];
  int    n_cmp = 0;
  int    n_bad = 0;

  // Monitor: outputs are combinational, so sample once per cycle and also
  // right after an asynchronous reset assertion.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(negedge clk or negedge reset_n);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        n_cmp++;
        if (fwd_sel[SEL_W-1:0] !== e.sel0 || fwd_sel[2*SEL_W-1:SEL_W] !== e.sel1 ||
            stall !== e.stl) begin
          n_bad++;
          $display("FAIL %s: got sel0=%0d sel1=%0d stall=%b, expected sel0=%0d sel1=%0d stall=%b",
                   nm, fwd_sel[SEL_W-1:0], fwd_sel[2*SEL_W-1:SEL_W], stall,
                   e.sel0, e.sel1, e.stl);
        end
      end
    end
  end

  // One decode cycle: inputs are applied just after the rising edge and hold
  // until the next one; optionally queue the expected outputs for this cycle.
  task automatic cyc(input logic iv, input logic iw, input logic il,
                     input logic [ADDR_W-1:0] id, input logic [1:0] sv,
                     input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                     input logic fl, input bit chk,
                     input logic [SEL_W-1:0] e0, input logic [SEL_W-1:0] e1,
                     input logic est, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    issue_valid = iv;
    issue_wr    = iw;
    issue_load  = il;
    issue_dst   = id;
    src_valid   = sv;
    src_addr    = {a1, a0};
    flush       = fl;
    if (chk) begin
      e.sel0 = e0;
      e.sel1 = e1;
      e.stl  = est;
      exp_q.push_back(e);
      name_q.push_back(nm);
    end
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, "");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    // Reset state
    cyc(0, 0, 0, 0, 2'b11, 0, 0, 0, 1, 0, 0, 0, "reset_state");
    @(negedge clk); #2; reset_n = 1'b1;

    // ALU chain
    cyc(1, 1, 0, 1, 2'b00, 0, 0, 0, 1, 0, 0, 0, "alu_issue");
    cyc(0, 0, 0, 0, 2'b01, 1, 0, 0, 1, 1, 0, 0, "alu_fwd_ex");
    cyc(0, 0, 0, 0, 2'b01, 1, 0, 0, 1, 2, 0, 0, "alu_fwd_mem");
    cyc(0, 0, 0, 0, 2'b01, 1, 0, 0, 1, 3, 0, 0, "alu_fwd_wb");

    // Load-use: X5 issued during the stall must be dropped
    cyc(1, 1, 1, 2, 2'b00, 0, 0, 0, 1, 0, 0, 0, "load_issue");
    cyc(1, 1, 0, 5, 2'b10, 0, 2, 0, 1, 0, 1, 1, "load_use_stall");
    cyc(0, 0, 0, 0, 2'b11, 5, 2, 0, 1, 0, 2, 0, "load_use_fwd_mem");
    idle();

    // Youngest wins: X3 in entries 0 and 2
    cyc(1, 1, 0, 3, 2'b00, 0, 0, 0, 0, 0, 0, 0, "");
    cyc(1, 1, 0, 4, 2'b00, 0, 0, 0, 0, 0, 0, 0, "");
    cyc(1, 1, 0, 3, 2'b11, 3, 4, 0, 1, 2, 1, 0, "mixed_ex_mem");
    cyc(0, 0, 0, 0, 2'b11, 3, 4, 0, 1, 1, 2, 0, "youngest_wins");

    // Zero register load in EX; issue_valid=0 with other fields set
    cyc(1, 1, 1, 31, 2'b00, 0, 0, 0, 0, 0, 0, 0, "");
    cyc(0, 1, 0, 6, 2'b11, 31, 3, 0, 1, 0, 3, 0, "zero_reg_load");
    cyc(0, 0, 0, 0, 2'b11, 6, 31, 0, 1, 0, 0, 0, "bubble_and_zero");

    // Flush with three valid producers
    cyc(1, 1, 0, 7, 2'b00, 0, 0, 0, 0, 0, 0, 0, "");
    cyc(1, 1, 0, 8, 2'b00, 0, 0, 0, 0, 0, 0, 0, "");
    cyc(1, 1, 0, 9, 2'b00, 0, 0, 0, 0, 0, 0, 0, "");
    cyc(0, 0, 0, 0, 2'b11, 7, 9, 1, 1, 3, 1, 0, "pre_flush");
    cyc(0, 0, 0, 0, 2'b11, 7, 8, 0, 1, 0, 0, 0, "post_flush");

    // Flush together with stall: flush wins, X11 not recorded
    cyc(1, 1, 1, 10, 2'b00, 0, 0, 0, 0, 0, 0, 0, "");
    cyc(1, 1, 0, 11, 2'b01, 10, 0, 1, 1, 1, 0, 1, "flush_with_stall");
    cyc(0, 0, 0, 0, 2'b11, 11, 10, 0, 1, 0, 0, 0, "after_flush_stall");

    // Reset asserted in the middle of a stall cycle
    cyc(1, 1, 1, 12, 2'b00, 0, 0, 0, 0, 0, 0, 0, "");
    cyc(0, 0, 0, 0, 2'b01, 12, 0, 0, 1, 1, 0, 1, "stall_before_reset");
    @(negedge clk); #3;
    e.sel0 = 0; e.sel1 = 0; e.stl = 0;
    exp_q.push_back(e);
    name_q.push_back("reset_mid_stall");
    reset_n = 1'b0;
    @(negedge clk); #2; reset_n = 1'b1;
    cyc(0, 0, 0, 0, 2'b01, 12, 0, 0, 1, 0, 0, 0, "after_reset");

`ifdef HAZ_STATS_EN
    // Two load-use stalls and five forwarding cycles since the last reset
    cyc(1, 1, 1, 2, 2'b00, 0, 0, 0, 0, 0, 0, 0, "");
    cyc(0, 0, 0, 0, 2'b01, 2, 0, 0, 1, 1, 0, 1, "stats_stall1");
    cyc(0, 0, 0, 0, 2'b01, 2, 0, 0, 1, 2, 0, 0, "stats_fwd1");
    cyc(1, 1, 1, 3, 2'b01, 2, 0, 0, 1, 3, 0, 0, "stats_fwd2");
    cyc(0, 0, 0, 0, 2'b01, 3, 0, 0, 1, 1, 0, 1, "stats_stall2");
    cyc(0, 0, 0, 0, 2'b01, 3, 0, 0, 1, 2, 0, 0, "stats_fwd3");
    cyc(0, 0, 0, 0, 2'b01, 3, 0, 0, 1, 3, 0, 0, "stats_fwd4");
    cyc(1, 1, 0, 4, 2'b00, 0, 0, 0, 0, 0, 0, 0, "");
    cyc(0, 0, 0, 0, 2'b01, 4, 0, 0, 1, 1, 0, 0, "stats_fwd5");
    idle();
    @(negedge clk); #2;
    n_cmp++;
    if (stall_cnt !== 32'd2) begin
      n_bad++;
      $display("FAIL stall_cnt: got %0d, expected 2", stall_cnt);
    end
    n_cmp++;
    if (fwd_cnt !== 32'd5) begin
      n_bad++;
      $display("FAIL fwd_cnt: got %0d, expected 5", fwd_cnt);
    end
    // Saturation
    force dut.r_stall_cnt = 32'hFFFF_FFFF;
    force dut.r_fwd_cnt   = 32'hFFFF_FFFF;
    #1;
    release dut.r_stall_cnt;
    release dut.r_fwd_cnt;
    cyc(1, 1, 1, 5, 2'b00, 0, 0, 0, 0, 0, 0, 0, "");
    cyc(0, 0, 0, 0, 2'b01, 5, 0, 0, 1, 1, 0, 1, "sat_stall");
    cyc(0, 0, 0, 0, 2'b01, 5, 0, 0, 1, 2, 0, 0, "sat_fwd");
    idle();
    @(negedge clk); #2;
    n_cmp++;
    if (stall_cnt !== 32'hFFFF_FFFF) begin
      n_bad++;
      $display("FAIL stall_cnt_sat: got %h, expected ffffffff", stall_cnt);
    end
    n_cmp++;
    if (fwd_cnt !== 32'hFFFF_FFFF) begin
      n_bad++;
      $display("FAIL fwd_cnt_sat: got %h, expected ffffffff", fwd_cnt);
    end
`endif

    idle();
    repeat (3) @(negedge clk);
    #3;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
